// File: rtl/past_checker_if.sv
// rtl/past_checker_if.sv - tap inputs and result outputs of the $past stage monitor
interface past_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             d;
  logic             q;
  logic             s;
  logic             past_valid;
  logic             err_q;
  logic             err_s;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] first_fail_cyc;

  modport master (
    output en, d, q, s,
    input  past_valid, err_q, err_s, fail, err_cnt, cyc, first_fail_cyc
  );

  modport slave (
    input  en, d, q, s,
    output past_valid, err_q, err_s, fail, err_cnt, cyc, first_fail_cyc
  );
endinterface

// File: rtl/past_checker.sv
// rtl/past_checker.sv - rebuilds the 1/2-cycle history of d and checks q/s against it
module past_checker #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  past_checker_if.slave bus
);
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             h1_q, h1_d;
  logic             h2_q, h2_d;
  logic [1:0]       vcnt_q, vcnt_d;
  logic             past_valid_q, past_valid_d;
  logic             err_q_q, err_q_d;
  logic             err_s_q, err_s_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;

  logic mq;
  logic ms;
  logic mis;

  // Checks use the pre-update history, so each is armed one edge after its tap exists.
  always_comb begin
    mq  = bus.en & (vcnt_q >= 2'd1) & (bus.q != h1_q);
    ms  = bus.en & (vcnt_q == 2'd2) & (bus.s != h2_q);
    mis = mq | ms;
  end

  always_comb begin
    h1_d         = bus.d;
    h2_d         = h1_q;
    vcnt_d       = (vcnt_q == 2'd2) ? vcnt_q : vcnt_q + 2'd1;
    past_valid_d = (vcnt_d == 2'd2);
    cyc_d        = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 1'b1;
    err_q_d      = err_q_q | mq;
    err_s_d      = err_s_q | ms;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    if (mis && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (mis && (state_q != ST_FAIL)) begin
      first_fail_d = cyc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WARMUP: begin
        if (mis) begin
          state_d = ST_FAIL;
        end else if (vcnt_d == 2'd2) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mis) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WARMUP;
      h1_q         <= 1'b0;
      h2_q         <= 1'b0;
      vcnt_q       <= 2'd0;
      past_valid_q <= 1'b0;
      err_q_q      <= 1'b0;
      err_s_q      <= 1'b0;
      err_cnt_q    <= '0;
      cyc_q        <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      vcnt_q       <= vcnt_d;
      past_valid_q <= past_valid_d;
      err_q_q      <= err_q_d;
      err_s_q      <= err_s_d;
      err_cnt_q    <= err_cnt_d;
      cyc_q        <= cyc_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign bus.past_valid     = past_valid_q;
  assign bus.err_q          = err_q_q;
  assign bus.err_s          = err_s_q;
  assign bus.fail           = (state_q == ST_FAIL);
  assign bus.err_cnt        = err_cnt_q;
  assign bus.cyc            = cyc_q;
  assign bus.first_fail_cyc = first_fail_q;
endmodule

// File: tb/tb_past_checker.sv
// tb/tb_past_checker.sv - self-checking bench for past_checker
module tb_past_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst3;

  past_checker_if #(.CNT_W(8)) bus ();
  past_checker_if #(.CNT_W(3)) bus3 ();

  past_checker #(.CNT_W(8)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  past_checker #(.CNT_W(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int errors = 0;
  int checks = 0;

  // Upstream $past stage: q <= d, s <= q (as presented), no reset.
  logic up_q = 1'b0;
  logic up_s = 1'b0;

  // Reference model: d samples since reset, and expected outputs.
  bit hist[$];
  int m_k;
  bit e_q, e_s, e_fail;
  int e_cnt, e_first;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_k = 0; e_q = 0; e_s = 0; e_fail = 0; e_cnt = 0; e_first = 0;
  endtask

  task automatic model_edge(input logic dv, input logic env, input logic qv, input logic sv);
    bit mq, ms;
    mq = env && (hist.size() >= 1) && (qv != hist[$]);
    ms = env && (hist.size() >= 2) && (sv != hist[$-1]);
    if (mq || ms) begin
      e_q = e_q | mq;
      e_s = e_s | ms;
      if (!e_fail) e_first = sat(m_k, 255);
      e_fail = 1;
      e_cnt = sat(e_cnt + 1, 255);
    end
    m_k++;
    hist.push_back(dv);
  endtask

  task automatic check_all();
    chk("past_valid", 32'(bus.past_valid), 32'(hist.size() >= 2));
    chk("err_q", 32'(bus.err_q), 32'(e_q));
    chk("err_s", 32'(bus.err_s), 32'(e_s));
    chk("fail", 32'(bus.fail), 32'(e_fail));
    chk("err_cnt", 32'(bus.err_cnt), 32'(e_cnt));
    chk("cyc", 32'(bus.cyc), 32'(sat(m_k, 255)));
    chk("first_fail_cyc", 32'(bus.first_fail_cyc), 32'(e_first));
  endtask

  task automatic step(input logic dv, input logic env, input logic fq, input logic fs);
    logic qp, sp;
    qp = up_q ^ fq;
    sp = up_s ^ fs;
    bus.d = dv; bus.en = env; bus.q = qp; bus.s = sp;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(dv, env, qp, sp);
    up_s = qp;
    up_q = dv;
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n, input logic fq);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b1, fq, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pat;
    logic prev3;
    pat = 5'b01101;
    rst = 1'b1; rst3 = 1'b1;
    bus.d = 0; bus.en = 1; bus.q = 0; bus.s = 0;
    bus3.d = 0; bus3.en = 1; bus3.q = 0; bus3.s = 0;
    model_reset();

    // Clean pass
    do_reset(2, 1'b0);
    chk("rst_fail", 32'(bus.fail), 32'd0);
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(pat[i % 5], 1'b1, 1'b0, 1'b0);
      if (i == 0) chk("pv_edge1", 32'(bus.past_valid), 32'd0);
      if (i == 1) chk("pv_edge2", 32'(bus.past_valid), 32'd1);
    end
    chk("clean_fail", 32'(bus.fail), 32'd0);
    chk("clean_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("clean_cyc", 32'(bus.cyc), 32'd20);

    // q fault sampled at edge 6
    do_reset(1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1'($urandom), 1'b1, 1'(e == 6), 1'b0);
      if (e == 6) begin
        chk("qf_err_q", 32'(bus.err_q), 32'd1);
        chk("qf_err_s", 32'(bus.err_s), 32'd0);
        chk("qf_fail", 32'(bus.fail), 32'd1);
        chk("qf_err_cnt", 32'(bus.err_cnt), 32'd1);
        chk("qf_first", 32'(bus.first_fail_cyc), 32'd5);
      end
      if (e == 7) begin
        chk("qf_err_s7", 32'(bus.err_s), 32'd1);
        chk("qf_err_cnt7", 32'(bus.err_cnt), 32'd2);
      end
    end

    // Warm-up gating of the s check
    do_reset(1, 1'b0);
    for (int e = 1; e <= 5; e++) step(1'($urandom), 1'b1, 1'b0, 1'(e <= 2));
    chk("wu_err_s", 32'(bus.err_s), 32'd0);
    chk("wu_fail", 32'(bus.fail), 32'd0);
    do_reset(1, 1'b0);
    for (int e = 1; e <= 4; e++) step(1'($urandom), 1'b1, 1'b0, 1'(e == 3));
    chk("wu3_err_s", 32'(bus.err_s), 32'd1);
    chk("wu3_first", 32'(bus.first_fail_cyc), 32'd2);

    // Enable masking
    do_reset(1, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      step(1'($urandom), 1'(e < 4 || e == 9), 1'(e >= 4), 1'b0);
      if (e == 8) chk("en_masked", 32'(bus.err_q), 32'd0);
    end
    chk("en_err_q9", 32'(bus.err_q), 32'd1);

    // Random run with sparse faults and enable toggling
    do_reset(1, 1'b0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));

    // Reset mid-FAIL, with a fault present on the reset edge
    do_reset(1, 1'b0);
    for (int e = 1; e <= 4; e++) step(1'($urandom), 1'b1, 1'(e == 3), 1'b0);
    chk("mf_fail_set", 32'(bus.fail), 32'd1);
    do_reset(1, 1'b1);
    chk("mf_fail_clr", 32'(bus.fail), 32'd0);
    chk("mf_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("mf_first", 32'(bus.first_fail_cyc), 32'd0);
    chk("mf_pv", 32'(bus.past_valid), 32'd0);
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("mf_clean_fail", 32'(bus.fail), 32'd0);

    // Saturation on the CNT_W=3 instance
    rst = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    prev3 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus3.d = 1'($urandom);
      bus3.q = ~prev3;
      prev3 = bus3.d;
      @(posedge clk); #1;
      chk("sat_cyc", 32'(bus3.cyc), 32'(sat(k, 7)));
      chk("sat_err_cnt", 32'(bus3.err_cnt), 32'(sat(k - 1, 7)));
    end
    chk("sat_first", 32'(bus3.first_fail_cyc), 32'd1);
    chk("sat_err_q", 32'(bus3.err_q), 32'd1);
    chk("sat_fail", 32'(bus3.fail), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
